alu_exec_queue: RTL and testbench

//   Execution stage fed directly by the reservation station. Takes one dispatched op per cycle
//   (Calc_en/OpCode/val1/val2/ROB number) and computes the integer/compare result in one cycle.

---
 rtl/alu_exec_queue_pkg.sv | 36 +++
 rtl/alu_exec_queue_core.sv | 57 +++++
 rtl/alu_exec_queue.sv | 129 ++++++++++++
 tb/tb_alu_exec_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_queue_pkg
//  Purpose  : Shared widths and opcode encoding for the ALU execution stage.
//             Consumers: alu_core (decode) and alu_exec_queue (port widths).
//  Contents : DATA_W, ROB_W, OP_W widths; OP_* opcode constants.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_exec_queue_pkg;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 5;
  localparam int OP_W   = 6;

  // Opcode encoding shared with the reservation station. Any value not listed
  // here is treated as unknown and produces a zero result.
  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd7;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 6'd9;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd10;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd11;
  localparam logic [OP_W-1:0] OP_BLT  = 6'd12;
  localparam logic [OP_W-1:0] OP_BGE  = 6'd13;
  localparam logic [OP_W-1:0] OP_BLTU = 6'd14;
  localparam logic [OP_W-1:0] OP_BGEU = 6'd15;
  localparam logic [OP_W-1:0] OP_LUI  = 6'd16;

endpackage : alu_exec_queue_pkg
`default_nettype wire

// File: rtl/alu_exec_queue_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational integer/compare unit.
//  Ports    : op     in  OP_W    operation select
//             val1   in  DATA_W  operand 1
//             val2   in  DATA_W  operand 2 (shift amount taken from [4:0])
//             result out DATA_W  operation result (0 for unknown opcodes)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_core #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] result
);
  import alu_exec_queue_pkg::*;

  logic [4:0] w_shamt;
  logic       w_lt;
  logic       w_ltu;
  logic       w_eq;

  assign w_shamt = val2[4:0];
  assign w_lt    = $signed(val1) < $signed(val2);
  assign w_ltu   = val1 < val2;
  assign w_eq    = val1 == val2;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = val1 + val2;
      OP_SUB:  result = val1 - val2;
      OP_AND:  result = val1 & val2;
      OP_OR:   result = val1 | val2;
      OP_XOR:  result = val1 ^ val2;
      OP_SLL:  result = val1 << w_shamt;
      OP_SRL:  result = val1 >> w_shamt;
      OP_SRA:  result = $signed(val1) >>> w_shamt;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, w_lt};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, w_ltu};
      OP_BEQ:  result = {{(DATA_W-1){1'b0}}, w_eq};
      OP_BNE:  result = {{(DATA_W-1){1'b0}}, ~w_eq};
      OP_BLT:  result = {{(DATA_W-1){1'b0}}, w_lt};
      OP_BGE:  result = {{(DATA_W-1){1'b0}}, ~w_lt};
      OP_BLTU: result = {{(DATA_W-1){1'b0}}, w_ltu};
      OP_BGEU: result = {{(DATA_W-1){1'b0}}, ~w_ltu};
      OP_LUI:  result = val2;
      default: result = '0;
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_exec_queue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_queue
//  Purpose  : ALU execution stage between reservation station and ROB.
//             Computes one op per cycle and buffers {tag,result} in a FIFO
//             drained by the ROB write-back port under valid/ready.
//  Ports    : clk_in, rst_n_in (async active-low), rdy_in (global enable),
//             clear (sync flush), Calc_en/OpCode_i/val1/val2/ROB_Number_i
//             (dispatch), alu_full (backpressure to RS), res_valid/res_ready/
//             res_val/res_rob (write-back), overflow_err (sticky).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_queue #(
  parameter int DATA_W = alu_exec_queue_pkg::DATA_W,
  parameter int ROB_W  = alu_exec_queue_pkg::ROB_W,
  parameter int OP_W   = alu_exec_queue_pkg::OP_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              Calc_en,
  input  logic [OP_W-1:0]   OpCode_i,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [ROB_W-1:0]  ROB_Number_i,
  output logic              alu_full,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_val,
  output logic [ROB_W-1:0]  res_rob,
  output logic              overflow_err
);
  import alu_exec_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_cnt_full   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_almost = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem_val [DEPTH];
  logic [ROB_W-1:0]  r_mem_rob [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_alu_full;
  logic              r_overflow;

  logic [DATA_W-1:0] w_result;
  logic              w_live;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic              w_overflow;
  logic [CNT_W-1:0]  w_cnt_nxt;

  alu_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu_core (
    .op     (OpCode_i),
    .val1   (val1),
    .val2   (val2),
    .result (w_result)
  );

  // A flush swallows both the same-cycle dispatch and the same-cycle pop.
  assign w_live     = rdy_in && !clear;
  assign w_push_req = w_live && Calc_en;
  assign w_pop      = w_live && res_valid && res_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign w_push     = w_push_req && ((r_count != c_cnt_full) || w_pop);
  assign w_overflow = w_push_req && (r_count == c_cnt_full) && !w_pop;

  always_comb begin
    w_cnt_nxt = r_count;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_cnt_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_alu_full <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_val[i] <= '0;
        r_mem_rob[i] <= '0;
      end
    end else if (rdy_in) begin
      r_count <= w_cnt_nxt;
      // Registered with one slot of slack: the RS may launch one more op in
      // the same cycle it samples this flag.
      r_alu_full <= (w_cnt_nxt >= c_cnt_almost);
      if (w_overflow) begin
        r_overflow <= 1'b1;
      end
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_val[r_wr_ptr] <= w_result;
          r_mem_rob[r_wr_ptr] <= ROB_Number_i;
          r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  assign res_valid    = (r_count != '0);
  assign res_val      = r_mem_val[r_rd_ptr];
  assign res_rob      = r_mem_rob[r_rd_ptr];
  assign alu_full     = r_alu_full;
  assign overflow_err = r_overflow;

endmodule : alu_exec_queue
`default_nettype wire

// File: tb/tb_alu_exec_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_queue
//  Purpose  : Directed self-checking bench for alu_exec_queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_queue;
  import alu_exec_queue_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              rdy_in;
  logic              clear;
  logic              Calc_en;
  logic [OP_W-1:0]   OpCode_i;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [ROB_W-1:0]  ROB_Number_i;
  logic              alu_full;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_val;
  logic [ROB_W-1:0]  res_rob;
  logic              overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  alu_exec_queue #(.DEPTH(4)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .Calc_en      (Calc_en),
    .OpCode_i     (OpCode_i),
    .val1         (val1),
    .val2         (val2),
    .ROB_Number_i (ROB_Number_i),
    .alu_full     (alu_full),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_val      (res_val),
    .res_rob      (res_rob),
    .overflow_err (overflow_err)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Dispatch one op with res_ready high: it appears at the head next cycle
  // and is popped on the edge after that.
  task automatic do_op(input string tag, input logic [OP_W-1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    Calc_en = 1'b1; OpCode_i = op; val1 = a; val2 = b; ROB_Number_i = 5'd3;
    tick;
    Calc_en = 1'b0;
    check({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
    check(tag, res_val, exp);
    tick;
  endtask

  // Tagged ADD whose result encodes the tag: t*16 + 1.
  task automatic push_tag(input logic [ROB_W-1:0] t);
    Calc_en = 1'b1; OpCode_i = OP_ADD; val1 = {23'b0, t, 4'b0}; val2 = 32'd1;
    ROB_Number_i = t;
    tick;
    Calc_en = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; Calc_en = 1'b0;
    OpCode_i = '0; val1 = '0; val2 = '0; ROB_Number_i = '0; res_ready = 1'b0;
    tick; tick;
    check("rst_valid",    {31'b0, res_valid},    32'd0);
    check("rst_full",     {31'b0, alu_full},     32'd0);
    check("rst_overflow", {31'b0, overflow_err}, 32'd0);
    check("rst_val",      res_val,               32'd0);
    check("rst_rob",      {27'b0, res_rob},      32'd0);
    rst_n_in = 1'b1;
    tick;

    // Single op latency and drain
    res_ready = 1'b1;
    Calc_en = 1'b1; OpCode_i = OP_ADD; val1 = 32'd7; val2 = 32'hFFFF_FFFF; ROB_Number_i = 5'd5;
    tick;
    Calc_en = 1'b0;
    check("single_valid", {31'b0, res_valid}, 32'd1);
    check("single_val",   res_val,            32'd6);
    check("single_rob",   {27'b0, res_rob},   32'd5);
    tick;
    check("single_drained", {31'b0, res_valid}, 32'd0);

    // Ops sweep
    do_op("sub",  OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
    do_op("and",  OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    do_op("or",   OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    do_op("xor",  OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    do_op("sll",  OP_SLL,  32'd1,         32'd35,        32'd8);
    do_op("srl",  OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000);
    do_op("sra",  OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000);
    do_op("sltu", OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1);
    do_op("slt",  OP_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0);
    do_op("beq",  OP_BEQ,  32'd5,         32'd5,         32'd1);
    do_op("bne",  OP_BNE,  32'd5,         32'd5,         32'd0);
    do_op("blt",  OP_BLT,  32'hFFFF_FFFF, 32'd0,         32'd1);
    do_op("bge",  OP_BGE,  32'hFFFF_FFFF, 32'd0,         32'd0);
    do_op("bltu", OP_BLTU, 32'hFFFF_FFFF, 32'd0,         32'd0);
    do_op("bgeu", OP_BGEU, 32'hFFFF_FFFF, 32'd0,         32'd1);
    do_op("lui",  OP_LUI,  32'h0000_DEAD, 32'h1234_5000, 32'h1234_5000);
    do_op("unknown", 6'd63, 32'd3,        32'd4,         32'd0);

    // Backpressure and overflow
    res_ready = 1'b0;
    push_tag(5'd1);
    check("bp_full_1", {31'b0, alu_full}, 32'd0);
    check("bp_head_1", {27'b0, res_rob},  32'd1);
    push_tag(5'd2);
    check("bp_full_2", {31'b0, alu_full}, 32'd0);
    push_tag(5'd3);
    check("bp_full_3", {31'b0, alu_full}, 32'd1);
    push_tag(5'd4);
    check("bp_full_4", {31'b0, alu_full},     32'd1);
    check("bp_ovf_4",  {31'b0, overflow_err}, 32'd0);
    push_tag(5'd9);
    check("bp_ovf_5",  {31'b0, overflow_err}, 32'd1);
    res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_drain_rob_%0d", i), {27'b0, res_rob}, i);
      check($sformatf("bp_drain_val_%0d", i), res_val, i * 16 + 1);
      tick;
    end
    check("bp_empty",      {31'b0, res_valid},    32'd0);
    check("bp_full_empty", {31'b0, alu_full},     32'd0);
    check("bp_ovf_sticky", {31'b0, overflow_err}, 32'd1);

    // Asynchronous reset mid-stream with three entries queued
    res_ready = 1'b0;
    push_tag(5'd1); push_tag(5'd2); push_tag(5'd3);
    check("arst_pre_full", {31'b0, alu_full}, 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_valid", {31'b0, res_valid},    32'd0);
    check("arst_full",  {31'b0, alu_full},     32'd0);
    check("arst_ovf",   {31'b0, overflow_err}, 32'd0);
    tick;
    rst_n_in = 1'b1;
    tick;

    // Full FIFO with simultaneous push and pop
    push_tag(5'd1); push_tag(5'd2); push_tag(5'd3); push_tag(5'd4);
    res_ready = 1'b1;
    push_tag(5'd5);
    res_ready = 1'b0;
    check("pp_ovf",   {31'b0, overflow_err}, 32'd0);
    check("pp_full",  {31'b0, alu_full},     32'd1);
    check("pp_valid", {31'b0, res_valid},    32'd1);
    res_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("pp_drain_rob_%0d", i), {27'b0, res_rob}, i);
      tick;
    end
    check("pp_empty", {31'b0, res_valid}, 32'd0);

    // Flush with a same-cycle dispatch
    res_ready = 1'b0;
    push_tag(5'd6); push_tag(5'd7);
    clear = 1'b1; res_ready = 1'b1;
    push_tag(5'd8);
    clear = 1'b0;
    check("flush_valid", {31'b0, res_valid}, 32'd0);
    check("flush_full",  {31'b0, alu_full},  32'd0);
    tick;
    check("flush_still_empty", {31'b0, res_valid}, 32'd0);
    check("flush_ovf", {31'b0, overflow_err}, 32'd0);

    // Stall: rdy_in low freezes everything
    res_ready = 1'b0;
    push_tag(5'd7);
    rdy_in = 1'b0; res_ready = 1'b1;
    push_tag(5'd9);
    tick;
    check("stall_valid", {31'b0, res_valid}, 32'd1);
    check("stall_rob",   {27'b0, res_rob},   32'd7);
    check("stall_val",   res_val,            32'd113);
    check("stall_full",  {31'b0, alu_full},  32'd0);
    rdy_in = 1'b1;
    tick;
    check("stall_release_pop", {31'b0, res_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_exec_queue
`default_nettype wire
